// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 6-digit common-anode 7-segment scan into a binary value.
// Optional `SEG_DEC_ERR_EN rejects frames containing unknown segment patterns.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [5:0]  sel,
    input  logic [7:0]  seg,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        frame_valid,
    output logic        err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Capture fires on the edge where the dwell counter steps onto STABLE_CNT-1.
    localparam logic [7:0] CAP_AT = 8'(STABLE_CNT - 2);

    state_t          state_q, state_d;
    logic [5:0]      prev_sel_q;
    logic [7:0]      prev_seg_q;
    logic [7:0]      dwell_q, dwell_d;
    logic [5:0][7:0] slot_q, slot_d;
    logic [5:0][7:0] snap_q, snap_d;
    logic [5:0]      seen_q, seen_d;
    logic            pend_q, pend_d;
    logic [2:0]      step_q, step_d;
    logic [19:0]     acc_q, acc_d;
    logic [5:0]      pnt_acc_q, pnt_acc_d;
    logic            sgn_acc_q, sgn_acc_d;
    logic [19:0]     data_q, data_d;
    logic [5:0]      point_q, point_d;
    logic            sign_q, sign_d;
    logic            fv_q, fv_d;
`ifdef SEG_DEC_ERR_EN
    logic            inv_acc_q, inv_acc_d;
    logic            err_q, err_d;
`endif

    logic            one_hot;
    logic            stable;
    logic            cap;
    logic [5:0]      seen_upd;
    logic            start;
    logic [7:0]      cur;

    function automatic logic [3:0] dec_digit(input logic [6:0] p);
        case (p)
            7'h40:   dec_digit = 4'd0;
            7'h79:   dec_digit = 4'd1;
            7'h24:   dec_digit = 4'd2;
            7'h30:   dec_digit = 4'd3;
            7'h19:   dec_digit = 4'd4;
            7'h12:   dec_digit = 4'd5;
            7'h02:   dec_digit = 4'd6;
            7'h78:   dec_digit = 4'd7;
            7'h00:   dec_digit = 4'd8;
            7'h10:   dec_digit = 4'd9;
            default: dec_digit = 4'd0;
        endcase
    endfunction

`ifdef SEG_DEC_ERR_EN
    function automatic logic dec_valid(input logic [6:0] p);
        case (p)
            7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
            7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
            7'h7F, 7'h3F: dec_valid = 1'b1;
            default:      dec_valid = 1'b0;
        endcase
    endfunction
`endif

    always_comb begin
        one_hot  = (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
        stable   = one_hot && (sel == prev_sel_q) && (seg == prev_seg_q);
        dwell_d  = stable ? ((dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1) : 8'd0;
        cap      = stable && (dwell_q == CAP_AT);
        seen_upd = seen_q | (cap ? sel : 6'd0);
        slot_d   = slot_q;
        for (int i = 0; i < 6; i++) begin
            if (cap && sel[i]) slot_d[i] = seg;
        end

        state_d   = state_q;
        seen_d    = seen_upd;
        pend_d    = pend_q;
        snap_d    = snap_q;
        step_d    = step_q;
        acc_d     = acc_q;
        pnt_acc_d = pnt_acc_q;
        sgn_acc_d = sgn_acc_q;
        data_d    = data_q;
        point_d   = point_q;
        sign_d    = sign_q;
        fv_d      = 1'b0;
        start     = 1'b0;
        cur       = snap_q[5];
`ifdef SEG_DEC_ERR_EN
        inv_acc_d = inv_acc_q;
        err_d     = 1'b0;
`endif

        case (state_q)
            COLLECT: begin
                if (seen_upd == 6'h3F || pend_q) start = 1'b1;
            end
            CONVERT: begin
                // Snapshot shifts left so the most significant slot is always at [5].
                acc_d     = acc_q * 20'd10 + {16'd0, dec_digit(cur[6:0])};
                pnt_acc_d = {pnt_acc_q[4:0], ~cur[7]};
                sgn_acc_d = sgn_acc_q | (cur[6:0] == 7'h3F);
                snap_d    = {snap_q[4:0], 8'hFF};
`ifdef SEG_DEC_ERR_EN
                inv_acc_d = inv_acc_q | ~dec_valid(cur[6:0]);
`endif
                step_d    = step_q + 3'd1;
                if (step_q == 3'd5) state_d = DONE;
                if (seen_upd == 6'h3F) pend_d = 1'b1;
            end
            DONE: begin
`ifdef SEG_DEC_ERR_EN
                if (inv_acc_q) begin
                    err_d = 1'b1;
                end else begin
                    data_d  = acc_q;
                    point_d = pnt_acc_q;
                    sign_d  = sgn_acc_q;
                    fv_d    = 1'b1;
                end
`else
                data_d  = acc_q;
                point_d = pnt_acc_q;
                sign_d  = sgn_acc_q;
                fv_d    = 1'b1;
`endif
                if (seen_upd == 6'h3F || pend_q) start = 1'b1;
                else state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase

        if (start) begin
            state_d   = CONVERT;
            snap_d    = slot_d;
            seen_d    = 6'd0;
            pend_d    = 1'b0;
            step_d    = 3'd0;
            acc_d     = 20'd0;
            pnt_acc_d = 6'd0;
            sgn_acc_d = 1'b0;
`ifdef SEG_DEC_ERR_EN
            inv_acc_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= COLLECT;
            prev_sel_q <= 6'd0;
            prev_seg_q <= 8'hFF;
            dwell_q    <= 8'd0;
            slot_q     <= {6{8'hFF}};
            snap_q     <= {6{8'hFF}};
            seen_q     <= 6'd0;
            pend_q     <= 1'b0;
            step_q     <= 3'd0;
            acc_q      <= 20'd0;
            pnt_acc_q  <= 6'd0;
            sgn_acc_q  <= 1'b0;
            data_q     <= 20'd0;
            point_q    <= 6'd0;
            sign_q     <= 1'b0;
            fv_q       <= 1'b0;
`ifdef SEG_DEC_ERR_EN
            inv_acc_q  <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            prev_sel_q <= sel;
            prev_seg_q <= seg;
            dwell_q    <= dwell_d;
            slot_q     <= slot_d;
            snap_q     <= snap_d;
            seen_q     <= seen_d;
            pend_q     <= pend_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            pnt_acc_q  <= pnt_acc_d;
            sgn_acc_q  <= sgn_acc_d;
            data_q     <= data_d;
            point_q    <= point_d;
            sign_q     <= sign_d;
            fv_q       <= fv_d;
`ifdef SEG_DEC_ERR_EN
            inv_acc_q  <= inv_acc_d;
            err_q      <= err_d;
`endif
        end
    end

    assign data        = data_q;
    assign point       = point_q;
    assign sign        = sign_q;
    assign frame_valid = fv_q;
    assign dbg_state   = state_q;
`ifdef SEG_DEC_ERR_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full frames plus hand-written
// sequences for short dwell, rejected frames, reset mid-conversion and back-to-back scans.
module tb_seg_scan_decoder;

    localparam int SC = 4;

    typedef struct packed {
        logic [47:0] segs;   // slot5 in [47:40] ... slot0 in [7:0]
        logic [19:0] data;
        logic [5:0]  point;
        logic        sign;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  sel = 6'd0;
    logic [7:0]  seg = 8'hFF;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        frame_valid;
    logic        err;
    logic [1:0]  dbg_state;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          fv_cnt = 0;
    int          err_cnt = 0;
    int          fv_cyc = 0;
    logic [19:0] fv_data [64];

    vec_t        vecs [7];

    seg_scan_decoder #(.STABLE_CNT(SC)) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .sel         (sel),
        .seg         (seg),
        .data        (data),
        .point       (point),
        .sign        (sign),
        .frame_valid (frame_valid),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_data[fv_cnt[5:0]] <= data;
            fv_cnt <= fv_cnt + 1;
            fv_cyc <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_slot(input int idx, input logic [7:0] s, input int hold, output int cap);
        @(negedge clk);
        sel = 6'(1 << idx);
        seg = s;
        cap = cyc + SC;
        repeat (hold) @(posedge clk);
    endtask

    task automatic run_frame(input logic [47:0] segs, input int hold, output int cap0);
        int c;
        c = 0;
        for (int i = 5; i >= 0; i--) drive_slot(i, segs[i*8 +: 8], hold, c);
        cap0 = c;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        sel = 6'd0;
        seg = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cap0;
        int fv0;
        int e0;

        vecs[0] = '{segs: 48'hFF_BF_90_80_78_82, data: 20'd9876,   point: 6'b000010, sign: 1'b1};
        vecs[1] = '{segs: 48'hC0_F9_A4_B0_99_92, data: 20'd12345,  point: 6'b000000, sign: 1'b0};
        vecs[2] = '{segs: 48'hC0_C0_C0_C0_C0_BF, data: 20'd0,      point: 6'b000000, sign: 1'b1};
        vecs[3] = '{segs: 48'h90_90_90_90_90_90, data: 20'd999999, point: 6'b000000, sign: 1'b0};
        vecs[4] = '{segs: 48'h7F_7F_7F_7F_7F_7F, data: 20'd0,      point: 6'b111111, sign: 1'b0};
        vecs[5] = '{segs: 48'h40_79_24_30_19_02, data: 20'd12346,  point: 6'b111111, sign: 1'b0};
        vecs[6] = '{segs: 48'hF8_80_82_92_99_B0, data: 20'd786543, point: 6'b000000, sign: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_point", point, 0);
        check("rst_sign", sign, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // Dwell one cycle too short: nothing may be captured
        run_frame(vecs[1].segs, SC - 1, cap0);
        idle(12);
        check("short_fv_cnt", fv_cnt, 0);
        check("short_err_cnt", err_cnt, 0);
        check("short_data", data, 0);
        check("short_point", point, 0);
        check("short_sign", sign, 0);

        // Table of full frames
        for (int v = 0; v < 7; v++) begin
            fv0 = fv_cnt;
            e0  = err_cnt;
            run_frame(vecs[v].segs, 10, cap0);
            idle(12);
            check($sformatf("v%0d_fv_cnt", v), fv_cnt - fv0, 1);
            check($sformatf("v%0d_err_cnt", v), err_cnt - e0, 0);
            check($sformatf("v%0d_data", v), data, vecs[v].data);
            check($sformatf("v%0d_point", v), point, vecs[v].point);
            check($sformatf("v%0d_sign", v), sign, vecs[v].sign);
            check($sformatf("v%0d_latency", v), fv_cyc - cap0, 7);
            check($sformatf("v%0d_fv_low", v), frame_valid, 0);
        end

        // Invalid pattern in slot 2
        fv0 = fv_cnt;
        e0  = err_cnt;
        run_frame(48'hC0_F9_A4_AA_99_92, 10, cap0);
        idle(12);
`ifdef SEG_DEC_ERR_EN
        check("inv_err_cnt", err_cnt - e0, 1);
        check("inv_fv_cnt", fv_cnt - fv0, 0);
        check("inv_data", data, 786543);
`else
        check("inv_err_cnt", err_cnt - e0, 0);
        check("inv_fv_cnt", fv_cnt - fv0, 1);
        check("inv_data", data, 12045);
        check("inv_point", point, 0);
`endif

        // Reset three cycles into conversion
        fv0 = fv_cnt;
        e0  = err_cnt;
        for (int i = 5; i >= 1; i--) drive_slot(i, vecs[1].segs[i*8 +: 8], 10, cap0);
        drive_slot(0, vecs[1].segs[7:0], SC, cap0);
        @(negedge clk);
        sel = 6'd0;
        seg = 8'hFF;
        repeat (3) @(posedge clk);
        #2;
        check("midrst_state_before", dbg_state, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_data", data, 0);
        check("midrst_point", point, 0);
        check("midrst_sign", sign, 0);
        check("midrst_fv", frame_valid, 0);
        check("midrst_err", err, 0);
        check("midrst_state", dbg_state, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst_no_fv", fv_cnt - fv0, 0);
        check("midrst_no_err", err_cnt - e0, 0);
        check("midrst_hold_data", data, 0);
        run_frame(vecs[0].segs, 10, cap0);
        idle(12);
        check("postrst_fv_cnt", fv_cnt - fv0, 1);
        check("postrst_data", data, 9876);
        check("postrst_point", point, 6'b000010);
        check("postrst_sign", sign, 1);

        // Three back-to-back frames of 999999
        fv0 = fv_cnt;
        e0  = err_cnt;
        for (int f = 0; f < 3; f++) run_frame(vecs[3].segs, 10, cap0);
        idle(12);
        check("scan3_fv_cnt", fv_cnt - fv0, 3);
        check("scan3_err_cnt", err_cnt - e0, 0);
        for (int k = 0; k < 3; k++) begin
            int pos;
            pos = (fv0 + k) % 64;
            check($sformatf("scan3_data%0d", k), fv_data[pos], 999999);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CNT, default 4, meaning consecutive cycles sel/seg must hold before a digit is captured (range 2..255).
REQ-002 sys_clk  input  1  single system clock; all state on rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 sel  input  6  scanned digit select, one-hot active-high; sel[0] = rightmost (least significant) digit.
REQ-005 seg  input  8  segment pattern, active-low, common-anode; seg[7] = dp, seg[6:0] = g..a.
REQ-006 data  output  20  binary value of the last accepted frame (0..999999).
REQ-007 point  output  6  decimal-point flags of the last accepted frame; point[i] set when slot i showed dp lit (seg[7]=0).
REQ-008 sign  output  1  set when any slot of the last accepted frame showed minus (8'hBF).
REQ-009 frame_valid  output  1  one-cycle pulse when data/point/sign update.
REQ-010 err  output  1  one-cycle pulse when a frame is rejected (see Configuration).

Function
REQ-011 Dwell counter increments while sel is one-hot and sel, seg equal their previous-cycle values; any change, sel=0 or non-one-hot sel clears it to 0.
REQ-012 Slot i captured exactly once per dwell when counter reaches STABLE_CNT-1; pattern stored in slot register i, bit i of seen mask set; no re-capture until sel/seg change.
REQ-013 Pattern decode (seg[6:0], dp ignored): 40/79/24/30/19/12/02/78/00/10 -> 0..9; 7F (blank) -> 0; 3F (minus) -> 0 with minus flag; anything else -> invalid.
REQ-014 Re-capture of an already-seen slot before mask is full overwrites that slot (latest wins).
REQ-015 FSM states COLLECT, CONVERT, DONE; reset state COLLECT.
REQ-016 COLLECT -> CONVERT on the cycle seen mask becomes 6'h3F: all six slots copied to a snapshot, mask cleared to 0, accumulator cleared.
REQ-017 CONVERT lasts exactly 6 cycles, processing slots 5 down to 0: acc = acc*10 + digit, 20-bit unsigned, no overflow possible (max 999999).
REQ-018 CONVERT -> DONE after slot 0; DONE asserts frame_valid (or err) for one cycle, updates outputs same cycle, returns to COLLECT.
REQ-019 Latency: frame_valid asserted 7 cycles after the capture completing the frame.
REQ-020 Captures continue during CONVERT/DONE into the live slot registers and mask; a frame completing in those states is held pending and starts CONVERT the cycle after DONE.
REQ-021 data, point, sign hold their values between frames; change only on frame_valid.

Reset
REQ-022 sys_rst_n low asynchronously forces: data=0, point=0, sign=0, frame_valid=0, err=0, dwell counter=0, seen mask=0, pending=0, state=COLLECT, slots=8'hFF.
REQ-023 Reset mid-CONVERT abandons the frame; no frame_valid or err after release.
REQ-024 First capture possible STABLE_CNT cycles after reset release with stable inputs.

Configuration
REQ-025 Macro SEG_DEC_ERR_EN defined: any invalid slot pattern in the snapshot makes DONE pulse err instead of frame_valid; data/point/sign unchanged.
REQ-026 SEG_DEC_ERR_EN undefined: invalid patterns decode as 0, frame always accepted with frame_valid, err tied to 0.

Verification
REQ-027 Slots 5..0 = FF, BF, 90, 80, 78, 82, each held 10 cycles, STABLE_CNT=4 -> frame_valid once, data=9876, point=6'b000010, sign=1.
REQ-028 Slots 5..0 = C0, F9, A4, B0, 99, 92 -> data=12345, point=0, sign=0; frame_valid exactly 7 cycles after slot-0 capture.
REQ-029 Each slot held only 3 cycles with STABLE_CNT=4 -> no capture, no frame_valid, outputs stay at reset values.
REQ-030 Slot 2 = 8'hAA in an otherwise valid frame -> with SEG_DEC_ERR_EN: err pulse, data unchanged; without: frame_valid with slot 2 treated as 0.
REQ-031 sys_rst_n pulled low 3 cycles into CONVERT -> all outputs 0 immediately, no pulse after release; next full frame decodes normally.
REQ-032 Continuous 6-digit scan of 999999 for 3 frames -> three frame_valid pulses, data=999999 each, no err.
